// File: rtl/y86_pkg.sv
// Y86-64 shared definitions for the decode stage.
//   - instruction codes HALT..POPQ and the NOP code loaded on a bubble
//   - register IDs: RNONE (no register) and RSP (%rsp)
//   - default datapath width and architectural register count
//   - reg_ids_t plus decode_ids(), which derives srcA/srcB/dstE/dstM
//     from icode and the rA/rB fields
package y86_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NREGS_DEF = 15;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] NOP_ICODE = I_NOP;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } reg_ids_t;

  // cmov (I_RRMOVQ) always names rB as dstE; execute squashes the write
  // when the condition fails, so decode does not look at ifun here.
  function automatic reg_ids_t decode_ids(input logic [3:0] icode,
                                          input logic [3:0] ra,
                                          input logic [3:0] rb);
    reg_ids_t ids;
    ids.src_a = RNONE;
    ids.src_b = RNONE;
    ids.dst_e = RNONE;
    ids.dst_m = RNONE;
    case (icode)
      I_RRMOVQ: begin
        ids.src_a = ra;
        ids.dst_e = rb;
      end
      I_IRMOVQ: begin
        ids.dst_e = rb;
      end
      I_RMMOVQ: begin
        ids.src_a = ra;
        ids.src_b = rb;
      end
      I_MRMOVQ: begin
        ids.src_b = rb;
        ids.dst_m = ra;
      end
      I_OPQ: begin
        ids.src_a = ra;
        ids.src_b = rb;
        ids.dst_e = rb;
      end
      I_CALL: begin
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_RET: begin
        ids.src_a = RSP;
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_PUSHQ: begin
        ids.src_a = ra;
        ids.src_b = RSP;
        ids.dst_e = RSP;
      end
      I_POPQ: begin
        ids.src_a = RSP;
        ids.src_b = RSP;
        ids.dst_e = RSP;
        ids.dst_m = ra;
      end
      default: begin
      end
    endcase
    return ids;
  endfunction

  // call and jXX carry the fall-through PC in valA instead of a register.
  function automatic logic uses_valp(input logic [3:0] icode);
    return (icode == I_JXX) || (icode == I_CALL);
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Y86-64 architectural register file: NREGS x WIDTH storage with two
// combinational read ports (A, B) and two write ports (E, M).
//   clk, reset          : clock; synchronous active-high clear of all entries
//   ra_idx_i/ra_data_o  : read port A index / data
//   rb_idx_i/rb_data_o  : read port B index / data
//   we_idx_i/we_data_i  : E write port (RNONE = no write)
//   wm_idx_i/wm_data_i  : M write port (RNONE = no write), wins over E
// Reading RNONE returns 0.
// Build option DECODE_BYPASS_EN: reads see same-cycle write data
// (M first, then E, then storage). Without it reads see storage only.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ra_idx_i,
  output logic [WIDTH-1:0] ra_data_o,
  input  logic [3:0]       rb_idx_i,
  output logic [WIDTH-1:0] rb_data_o,
  input  logic [3:0]       we_idx_i,
  input  logic [WIDTH-1:0] we_data_i,
  input  logic [3:0]       wm_idx_i,
  input  logic [WIDTH-1:0] wm_data_i
);

  logic [WIDTH-1:0] regs_q [NREGS];

  // M is checked first so popq %rsp leaves the popped value, not the
  // incremented stack pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wm_idx_i == 4'(i)) begin
          regs_q[i] <= wm_data_i;
        end else if (we_idx_i == 4'(i)) begin
          regs_q[i] <= we_data_i;
        end
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [3:0] idx);
    logic [WIDTH-1:0] data;
    data = '0;
    if (idx != RNONE) begin
`ifdef DECODE_BYPASS_EN
      if (idx == wm_idx_i) begin
        data = wm_data_i;
      end else if (idx == we_idx_i) begin
        data = we_data_i;
      end else begin
        data = regs_q[idx];
      end
`else
      data = regs_q[idx];
`endif
    end
    return data;
  endfunction

  always_comb begin
    ra_data_o = read_port(ra_idx_i);
    rb_data_o = read_port(rb_idx_i);
  end

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: register-ID derivation, operand read, valA select
// and the D->E pipeline register.
//   clk, reset                  : clock; synchronous active-high reset
//   d_valid/d_icode/d_ifun      : decode slot and instruction codes
//   d_rA/d_rB/d_valC/d_valP     : register fields, constant word, next PC
//   stall/bubble                : hazard control for the D->E register
//   w_dstE/w_valE, w_dstM/w_valM: write-back ports into the register file
//   e_*                         : registered D->E outputs
// D->E priority per clock: reset > bubble > stall > load.
// Build option DECODE_BYPASS_EN selects write-through reads in the
// register file; by default a write is visible to decode one cycle later.
module decode_regfile
  import y86_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [3:0]       d_rA,
  input  logic [3:0]       d_rB,
  input  logic [WIDTH-1:0] d_valC,
  input  logic [WIDTH-1:0] d_valP,
  input  logic             stall,
  input  logic             bubble,
  input  logic [3:0]       w_dstE,
  input  logic [WIDTH-1:0] w_valE,
  input  logic [3:0]       w_dstM,
  input  logic [WIDTH-1:0] w_valM,
  output logic             e_valid,
  output logic [3:0]       e_icode,
  output logic [3:0]       e_ifun,
  output logic [WIDTH-1:0] e_valA,
  output logic [WIDTH-1:0] e_valB,
  output logic [WIDTH-1:0] e_valC,
  output logic [3:0]       e_srcA,
  output logic [3:0]       e_srcB,
  output logic [3:0]       e_dstE,
  output logic [3:0]       e_dstM
);

  typedef struct packed {
    logic             valid;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic [WIDTH-1:0] val_c;
    reg_ids_t         ids;
  } de_t;

  reg_ids_t         ids;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  de_t              de_nop;
  de_t              de_load;
  de_t              de_d;
  de_t              de_q;

  // An empty slot must not name registers, or the hazard unit would see
  // phantom dependencies downstream.
  always_comb begin
    ids = decode_ids(d_icode, d_rA, d_rB);
    if (!d_valid) begin
      ids.src_a = RNONE;
      ids.src_b = RNONE;
      ids.dst_e = RNONE;
      ids.dst_m = RNONE;
    end
  end

  regfile_2r2w #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .ra_idx_i (ids.src_a),
    .ra_data_o(rd_a),
    .rb_idx_i (ids.src_b),
    .rb_data_o(rd_b),
    .we_idx_i (w_dstE),
    .we_data_i(w_valE),
    .wm_idx_i (w_dstM),
    .wm_data_i(w_valM)
  );

  always_comb begin
    de_nop.valid     = 1'b0;
    de_nop.icode     = NOP_ICODE;
    de_nop.ifun      = 4'h0;
    de_nop.val_a     = '0;
    de_nop.val_b     = '0;
    de_nop.val_c     = '0;
    de_nop.ids.src_a = RNONE;
    de_nop.ids.src_b = RNONE;
    de_nop.ids.dst_e = RNONE;
    de_nop.ids.dst_m = RNONE;

    de_load.valid = d_valid;
    de_load.icode = d_icode;
    de_load.ifun  = d_ifun;
    de_load.val_a = uses_valp(d_icode) ? d_valP : rd_a;
    de_load.val_b = rd_b;
    de_load.val_c = d_valC;
    de_load.ids   = ids;

    de_d = de_q;
    if (bubble) begin
      de_d = de_nop;
    end else if (!stall) begin
      de_d = de_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_q <= de_nop;
    end else begin
      de_q <= de_d;
    end
  end

  assign e_valid = de_q.valid;
  assign e_icode = de_q.icode;
  assign e_ifun  = de_q.ifun;
  assign e_valA  = de_q.val_a;
  assign e_valB  = de_q.val_b;
  assign e_valC  = de_q.val_c;
  assign e_srcA  = de_q.ids.src_a;
  assign e_srcB  = de_q.ids.src_b;
  assign e_dstE  = de_q.ids.dst_e;
  assign e_dstM  = de_q.ids.dst_m;

endmodule
